// File: rtl/ps2_device_tx.sv
// PS/2 device-side transmitter: generates the PS/2 clock and shifts out one
// 11-bit frame (start 0, 8 data bits LSB first, odd parity, stop 1) per byte.
// A host that holds the clock low at the end of a high phase aborts the frame.
// Optional feature: define PS2_TX_PARITY_ERR_INJECT_EN so that inject_perr
// inverts the parity bit of the accepted frame. Without the macro the port is
// present but ignored.
module ps2_device_tx #(
  parameter int HALF_PERIOD = 2000
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       inject_perr,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_abort
);

  localparam int CNT_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_PERIOD - 1);
  localparam logic [3:0] LAST_BIT = 4'd10;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_IDLE,
    HIGH,
    LOW
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       idx, idx_nxt;
  logic [10:0]      frame, frame_nxt;
  logic             clk_oe_nxt, data_oe_nxt, done_nxt, abort_nxt, ready_nxt;
  logic             par_bit;
  logic             unused_data;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

`ifdef PS2_TX_PARITY_ERR_INJECT_EN
  assign par_bit = odd_parity(tx_data) ^ inject_perr;
`else
  logic unused_perr;
  assign par_bit     = odd_parity(tx_data);
  assign unused_perr = inject_perr;
`endif

  // The data line is only driven by this block; the host side is not monitored.
  assign unused_data = ps2_data_i;
  assign busy        = (state != IDLE);

  // Next-state, phase timing and line drive decisions.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    idx_nxt     = idx;
    frame_nxt   = frame;
    clk_oe_nxt  = ps2_clk_oe;
    data_oe_nxt = ps2_data_oe;
    done_nxt    = 1'b0;
    abort_nxt   = 1'b0;
    case (state)
      IDLE: begin
        clk_oe_nxt  = 1'b0;
        data_oe_nxt = 1'b0;
        if (tx_valid && tx_ready) begin
          frame_nxt = {1'b1, par_bit, tx_data, 1'b0};
          idx_nxt   = 4'd0;
          cnt_nxt   = '0;
          state_nxt = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        // The clock line must be seen released for a full half period first.
        if (!ps2_clk_i) begin
          cnt_nxt = '0;
        end else if (cnt == CNT_LAST) begin
          cnt_nxt     = '0;
          state_nxt   = HIGH;
          data_oe_nxt = ~frame[idx];
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      HIGH: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt = '0;
          if (!ps2_clk_i && (idx < LAST_BIT)) begin
            state_nxt   = IDLE;
            clk_oe_nxt  = 1'b0;
            data_oe_nxt = 1'b0;
            abort_nxt   = 1'b1;
          end else begin
            state_nxt  = LOW;
            clk_oe_nxt = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      LOW: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt = '0;
          idx_nxt = idx + 4'd1;
          if (idx == LAST_BIT) begin
            state_nxt   = IDLE;
            clk_oe_nxt  = 1'b0;
            data_oe_nxt = 1'b0;
            done_nxt    = 1'b1;
          end else begin
            state_nxt   = HIGH;
            clk_oe_nxt  = 1'b0;
            data_oe_nxt = ~frame[idx_nxt];
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    ready_nxt = (state_nxt == IDLE);
  end

  // Control state and registered outputs; reset releases both lines at once.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= 4'd0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      tx_done     <= 1'b0;
      tx_abort    <= 1'b0;
      tx_ready    <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      idx         <= idx_nxt;
      ps2_clk_oe  <= clk_oe_nxt;
      ps2_data_oe <= data_oe_nxt;
      tx_done     <= done_nxt;
      tx_abort    <= abort_nxt;
      tx_ready    <= ready_nxt;
    end
  end

  // Frame shift image, loaded only on accept.
  always_ff @(posedge clk_in) begin
    frame <= frame_nxt;
  end

endmodule

// File: tb/tb_ps2_device_tx.sv
// Bench for ps2_device_tx with HALF_PERIOD=4. A behavioural timeline model
// predicts every output per cycle from the frame bits and the host clock
// activity; honours PS2_TX_PARITY_ERR_INJECT_EN the same way as the design.
module tb_ps2_device_tx;

  localparam int HP = 4;
`ifdef PS2_TX_PARITY_ERR_INJECT_EN
  localparam bit INJ_EN = 1'b1;
`else
  localparam bit INJ_EN = 1'b0;
`endif

  logic       clk_in = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       inject_perr;
  logic       host_clk;
  logic       ps2_clk_i;
  logic       ps2_data_i;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       busy;
  logic       tx_done;
  logic       tx_abort;

  int n_checks = 0;
  int n_pass   = 0;

  // Open-collector lines: low if either end pulls.
  assign ps2_clk_i  = host_clk & ~ps2_clk_oe;
  assign ps2_data_i = ~ps2_data_oe;

  always #5 clk_in = ~clk_in;

  ps2_device_tx #(.HALF_PERIOD(HP)) dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .inject_perr (inject_perr),
    .ps2_clk_i   (ps2_clk_i),
    .ps2_data_i  (ps2_data_i),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .busy        (busy),
    .tx_done     (tx_done),
    .tx_abort    (tx_abort)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [5:0] obs();
    return {ps2_clk_oe, ps2_data_oe, busy, tx_ready, tx_done, tx_abort};
  endfunction

  // One transaction: accept byte d, host holds clock low for hold_low samples,
  // optional host abort during the high phase of bit abort_bit, optional reset
  // injected just after cycle rst_at.
  task automatic run_frame(input logic [7:0] d, input bit perr, input int hold_low,
                           input int abort_bit, input int rst_at);
    logic [10:0] bits;
    logic [5:0]  exp;
    int          w, e, p;
    bit          par, host;
    par  = (($countones(d) % 2) == 0);
    if (INJ_EN && perr) par = ~par;
    bits = {1'b1, par, d, 1'b0};
    w    = hold_low + HP;
    e    = (abort_bit >= 0) ? (w + 2*HP*abort_bit + HP) : (w + 22*HP);

    chk("ready_pre", tx_ready, 1'b1);
    tx_data     = d;
    inject_perr = perr;
    tx_valid    = 1'b1;
    host_clk    = (hold_low > 0) ? 1'b0 : 1'b1;
    @(posedge clk_in); #1;

    for (int t = 0; t <= e + 2; t++) begin
      if (t > 0) begin
        host = !(t <= hold_low);
        if (abort_bit >= 0 && t >= e - 2 && t <= e) host = 1'b0;
        host_clk    = host;
        tx_valid    = (t < e) ? 1'($urandom % 2) : 1'b0;
        tx_data     = 8'($urandom);
        inject_perr = 1'($urandom % 2);
        @(posedge clk_in); #1;
      end
      if (t < w) begin
        exp = 6'b001000;
      end else if (t < e) begin
        p   = (t - w) / HP;
        exp = {1'(p % 2), ~bits[p/2], 1'b1, 1'b0, 1'b0, 1'b0};
      end else if (t == e) begin
        exp = {4'b0001, 1'(abort_bit < 0), 1'(abort_bit >= 0)};
      end else begin
        exp = 6'b000100;
      end
      chk($sformatf("frame %02h t=%0d", d, t), obs(), exp);
      if (t == rst_at) begin
        #2 reset = 1'b1;
        #1 chk("rst_async", obs(), 6'b000000);
        for (int k = 0; k < 2; k++) begin
          @(posedge clk_in); #1;
          chk("rst_hold", obs(), 6'b000000);
        end
        @(negedge clk_in);
        reset = 1'b0;
        @(posedge clk_in); #1;
        chk("rst_rel_mid", obs(), 6'b000100);
        break;
      end
    end
    host_clk = 1'b1;
    tx_valid = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    tx_data     = 8'h00;
    tx_valid    = 1'b0;
    inject_perr = 1'b0;
    host_clk    = 1'b1;
    repeat (3) @(posedge clk_in);
    #1 chk("rst", obs(), 6'b000000);
    @(negedge clk_in);
    reset = 1'b0;
    @(posedge clk_in); #1;
    chk("rst_rel", obs(), 6'b000100);

    run_frame(8'hF4, 1'b0, 0, -1, -1);
    run_frame(8'hFA, 1'b0, 0, -1, -1);
    run_frame(8'h3C, 1'b0, 20, -1, -1);
    run_frame(8'h5A, 1'b0, 0, 3, -1);
    run_frame(8'hF4, 1'b1, 0, -1, -1);
    run_frame(8'hA5, 1'b0, 0, -1, HP + 11*HP + 1);
    run_frame(8'h00, 1'b0, 0, -1, -1);

    for (int i = 0; i < 10; i++) begin
      run_frame(8'($urandom), 1'($urandom % 2), int'($urandom % 7),
                (($urandom % 4) == 0) ? int'($urandom % 10) : -1, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
